multicycle_controller: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, instruction/data memory port, register file and PC over several cycles per instruction.
- Drives the 2-bit ALUOp consumed by the ALU decoder, plus all datapath mux selects and write enables.
- Sits between the instruction register (opcode/funct3 fields) and the datapath; stalls on a memory ready handshake.

---
 rtl/multicycle_controller_pkg.sv | 89 ++++++++
 rtl/multicycle_controller_if.sv | 39 +++
 rtl/multicycle_controller_output_decode.sv | 88 ++++++++
 rtl/multicycle_controller.sv | 108 ++++++++++
 tb/tb_multicycle_controller.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes, ALUOp and datapath mux selects, plus the control-word layout.
package core_ctrl_pkg;

    // Controller states; FETCH must stay at 0 so a cleared register means FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

    // Supported major opcodes (instruction[6:0]).
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALUOp as consumed by the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // Register-file write-back source.
    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_RDATA     = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    // ALU operand A source.
    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_e;

    // ALU operand B source.
    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    // Per-state control word. The *_commit / branch_pc / mem_wait flags are
    // qualified with live inputs (i_memReady, i_zero, i_funct3) in the top.
    typedef struct packed {
        logic        pc_write;      // unconditional PC update
        logic        fetch_commit;  // PC and IR update when memory is ready
        logic        branch_pc;     // PC update on branch-taken condition
        logic        adr_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        illegal;
        logic        mem_wait;      // state stalls on i_memReady
        result_src_e result_src;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        alu_op_e     alu_op;
    } ctrl_word_t;

    // Instruction class selection made in DECODE.
    function automatic state_e decode_opcode(input logic [6:0] opcode);
        state_e nxt;
        case (opcode)
            OP_LOAD, OP_STORE: nxt = S_MEMADR;
            OP_RTYPE:          nxt = S_EXECR;
            OP_ITYPE:          nxt = S_EXECI;
            OP_BRANCH:         nxt = S_BRANCH;
            OP_JAL:            nxt = S_JAL;
            default:           nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and status flags in,
// enables and mux selects out. Signal names are from the controller's view.
interface multicycle_controller_if;

    logic [6:0] i_opcode;
    logic [2:0] i_funct3;
    logic       i_zero;
    logic       i_memReady;

    logic       o_PCWrite;
    logic       o_AdrSrc;
    logic       o_MemRead;
    logic       o_MemWrite;
    logic       o_IRWrite;
    logic       o_RegWrite;
    logic [1:0] o_ResultSrc;
    logic [1:0] o_ALUSrcA;
    logic [1:0] o_ALUSrcB;
    logic [1:0] o_ALUOp;
    logic       o_illegal;
    logic       o_memTimeout;

    // Controller side.
    modport master (
        input  i_opcode, i_funct3, i_zero, i_memReady,
        output o_PCWrite, o_AdrSrc, o_MemRead, o_MemWrite, o_IRWrite,
               o_RegWrite, o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp,
               o_illegal, o_memTimeout
    );

    // Datapath / instruction-register side.
    modport slave (
        output i_opcode, i_funct3, i_zero, i_memReady,
        input  o_PCWrite, o_AdrSrc, o_MemRead, o_MemWrite, o_IRWrite,
               o_RegWrite, o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp,
               o_illegal, o_memTimeout
    );

endinterface

// File: rtl/multicycle_controller_output_decode.sv
// Pure state -> control-word map for the multicycle controller.
// Input-dependent qualification is left to the top level.
module mc_output_decode
    import core_ctrl_pkg::*;
(
    input  state_e     state_i,
    output ctrl_word_t ctrl_o
);

    // Control word per state; anything not set stays 0.
    always_comb begin
        // NOTE: every field gets a value before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read     = 1'b1;
                ctrl_o.fetch_commit = 1'b1;
                ctrl_o.mem_wait     = 1'b1;
                ctrl_o.alu_src_a    = SRCA_PC;
                ctrl_o.alu_src_b    = SRCB_FOUR;
                ctrl_o.alu_op       = ALUOP_ADD;
                ctrl_o.result_src   = RES_ALURESULT;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = SRCA_OLDPC;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.mem_wait   = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl_o.result_src = RES_RDATA;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.mem_wait   = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
            end
            S_EXECR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_RS2;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.branch_pc  = 1'b1;
            end
            S_JAL: begin
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_write   = 1'b1;
            end
            S_ILLEGAL: begin
                ctrl_o.illegal = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and write-back, stalls on the memory ready handshake and
// flags memory waits that run past MEM_WAIT_MAX cycles.
module multicycle_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 16
)
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    multicycle_controller_if.master bus
);

    localparam int unsigned CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(MEM_WAIT_MAX);
    localparam logic TIMEOUT_EN = (MEM_WAIT_MAX != 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    state_e     dec_state;
    ctrl_word_t ctrl;
    logic       en_ok;
    logic       stall;
    logic       branch_taken;

    // Only funct3[0] selects between beq and bne; the upper bits are don't-care.
    logic unused_funct3_hi;
    assign unused_funct3_hi = ^bus.i_funct3[2:1];

    // While reset is held the outputs show FETCH selects with enables off.
    assign dec_state = i_rst ? S_FETCH : state_q;
    assign en_ok     = ~i_rst;

    mc_output_decode u_output_decode (
        .state_i (dec_state),
        .ctrl_o  (ctrl)
    );

    assign stall        = ctrl.mem_wait & ~bus.i_memReady;
    assign branch_taken = bus.i_zero ^ bus.i_funct3[0];

    // Next-state selection; memory states hold until i_memReady.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.i_memReady) state_d = S_DECODE;
            S_DECODE:   state_d = decode_opcode(bus.i_opcode);
            S_MEMADR:   state_d = bus.i_opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.i_memReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (bus.i_memReady) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Saturating stall counter, cleared whenever the state moves; the timeout
    // flag is sticky and never aborts the pending access.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (stall && (wait_cnt_q != WAIT_MAX_C)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (TIMEOUT_EN & (wait_cnt_d == WAIT_MAX_C));
    end

    // State, counter and timeout registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (i_rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Enables are gated by reset; conditional ones are qualified by live inputs.
    assign bus.o_PCWrite    = en_ok & (ctrl.pc_write
                                     | (ctrl.fetch_commit & bus.i_memReady)
                                     | (ctrl.branch_pc & branch_taken));
    assign bus.o_IRWrite    = en_ok & ctrl.fetch_commit & bus.i_memReady;
    assign bus.o_MemRead    = en_ok & ctrl.mem_read;
    assign bus.o_MemWrite   = en_ok & ctrl.mem_write;
    assign bus.o_RegWrite   = en_ok & ctrl.reg_write;
    assign bus.o_illegal    = en_ok & ctrl.illegal;
    assign bus.o_AdrSrc     = ctrl.adr_src;
    assign bus.o_ResultSrc  = ctrl.result_src;
    assign bus.o_ALUSrcA    = ctrl.alu_src_a;
    assign bus.o_ALUSrcB    = ctrl.alu_src_b;
    assign bus.o_ALUOp      = ctrl.alu_op;
    assign bus.o_memTimeout = timeout_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into the
// expected cycle-by-cycle control trace from its class and stall counts,
// then driven and compared; random instructions, stalls and resets follow
// the directed cases.
module tb_multicycle_controller;

    localparam int WAIT_MAX = 4;

    localparam bit [6:0] LOAD   = 7'b0000011;
    localparam bit [6:0] STORE  = 7'b0100011;
    localparam bit [6:0] RTYPE  = 7'b0110011;
    localparam bit [6:0] ITYPE  = 7'b0010011;
    localparam bit [6:0] BRANCH = 7'b1100011;
    localparam bit [6:0] JAL    = 7'b1101111;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // One expected cycle: inputs to drive and outputs required.
    typedef struct {
        string    tag;
        bit [6:0] opc;
        bit [2:0] f3;
        bit       rdy, zero, wait_ph;
        bit       pcw, adr, mr, mw, irw, rw, ill;
        bit [1:0] rs, a, b, op;
    } cyc_t;

    cyc_t     trace[$];
    int       n_total = 0;
    int       n_bad   = 0;
    bit       exp_to  = 1'b0;
    int       stall_run = 0;
    bit [6:0] cur_opc;
    bit [2:0] cur_f3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic cyc_t blank(input string tag);
        cyc_t c;
        c.tag = tag; c.opc = cur_opc; c.f3 = cur_f3;
        c.rdy = 1'($urandom); c.zero = 1'($urandom); c.wait_ph = 1'b0;
        c.pcw = 0; c.adr = 0; c.mr = 0; c.mw = 0; c.irw = 0; c.rw = 0; c.ill = 0;
        c.rs = 0; c.a = 0; c.b = 0; c.op = 0;
        return c;
    endfunction

    // Fetch: read at PC, compute PC+4; commit PC and IR on the ready cycle.
    task automatic push_fetch(input int stalls);
        cyc_t c;
        for (int i = 0; i <= stalls; i++) begin
            c = blank("fetch");
            c.wait_ph = 1'b1; c.mr = 1'b1; c.b = 2'b10; c.rs = 2'b10;
            c.rdy = (i == stalls);
            c.pcw = c.rdy; c.irw = c.rdy;
            trace.push_back(c);
        end
    endtask

    // Data access at ALUOut, held for the stall cycles plus the ready cycle.
    task automatic push_mem(input string tag, input bit is_write, input int stalls);
        cyc_t c;
        for (int i = 0; i <= stalls; i++) begin
            c = blank(tag);
            c.wait_ph = 1'b1; c.adr = 1'b1;
            c.mr = ~is_write; c.mw = is_write;
            c.rdy = (i == stalls);
            trace.push_back(c);
        end
    endtask

    task automatic build_instr(input bit [6:0] opc, input bit [2:0] f3,
                               input int fst, input int mst, input int zsel);
        cyc_t c;
        cur_opc = opc; cur_f3 = f3;
        trace.delete();
        push_fetch(fst);
        c = blank("decode"); c.a = 2'b01; c.b = 2'b01; trace.push_back(c);
        if (opc == LOAD || opc == STORE) begin
            c = blank("memadr"); c.a = 2'b10; c.b = 2'b01; trace.push_back(c);
            if (opc == STORE) begin
                push_mem("memwrite", 1'b1, mst);
            end else begin
                push_mem("memread", 1'b0, mst);
                c = blank("memwb"); c.rs = 2'b01; c.rw = 1'b1; trace.push_back(c);
            end
        end else if (opc == RTYPE || opc == ITYPE) begin
            c = blank("exec"); c.a = 2'b10; c.b = (opc == ITYPE) ? 2'b01 : 2'b00;
            c.op = 2'b10; trace.push_back(c);
            c = blank("aluwb"); c.rw = 1'b1; trace.push_back(c);
        end else if (opc == BRANCH) begin
            c = blank("branch"); c.a = 2'b10; c.op = 2'b01;
            if (zsel >= 0) c.zero = zsel[0];
            c.pcw = c.zero ^ f3[0];
            trace.push_back(c);
        end else if (opc == JAL) begin
            c = blank("jal"); c.a = 2'b01; c.b = 2'b10; c.pcw = 1'b1; trace.push_back(c);
            c = blank("aluwb"); c.rw = 1'b1; trace.push_back(c);
        end else begin
            c = blank("illegal"); c.ill = 1'b1; trace.push_back(c);
        end
    endtask

    task automatic run_cycle(input cyc_t c);
        @(negedge clk);
        rst = 1'b0;
        bus.i_opcode = c.opc; bus.i_funct3 = c.f3;
        bus.i_memReady = c.rdy; bus.i_zero = c.zero;
        #1;
        check({c.tag, ".PCWrite"},   32'(bus.o_PCWrite),   32'(c.pcw));
        check({c.tag, ".AdrSrc"},    32'(bus.o_AdrSrc),    32'(c.adr));
        check({c.tag, ".MemRead"},   32'(bus.o_MemRead),   32'(c.mr));
        check({c.tag, ".MemWrite"},  32'(bus.o_MemWrite),  32'(c.mw));
        check({c.tag, ".IRWrite"},   32'(bus.o_IRWrite),   32'(c.irw));
        check({c.tag, ".RegWrite"},  32'(bus.o_RegWrite),  32'(c.rw));
        check({c.tag, ".ResultSrc"}, 32'(bus.o_ResultSrc), 32'(c.rs));
        check({c.tag, ".ALUSrcA"},   32'(bus.o_ALUSrcA),   32'(c.a));
        check({c.tag, ".ALUSrcB"},   32'(bus.o_ALUSrcB),   32'(c.b));
        check({c.tag, ".ALUOp"},     32'(bus.o_ALUOp),     32'(c.op));
        check({c.tag, ".illegal"},   32'(bus.o_illegal),   32'(c.ill));
        check({c.tag, ".memTimeout"}, 32'(bus.o_memTimeout), 32'(exp_to));
        // Timeout model: a run of WAIT_MAX consecutive stalled cycles sets it.
        if (c.wait_ph && !c.rdy) stall_run++;
        else stall_run = 0;
        if (stall_run >= WAIT_MAX) exp_to = 1'b1;
    endtask

    task automatic run_reset_cycle();
        @(negedge clk);
        rst = 1'b1;
        bus.i_memReady = 1'($urandom); bus.i_zero = 1'($urandom);
        bus.i_opcode = 7'($urandom);
        #1;
        check("rst.PCWrite",    32'(bus.o_PCWrite),    32'd0);
        check("rst.IRWrite",    32'(bus.o_IRWrite),    32'd0);
        check("rst.RegWrite",   32'(bus.o_RegWrite),   32'd0);
        check("rst.MemWrite",   32'(bus.o_MemWrite),   32'd0);
        check("rst.MemRead",    32'(bus.o_MemRead),    32'd0);
        check("rst.illegal",    32'(bus.o_illegal),    32'd0);
        check("rst.AdrSrc",     32'(bus.o_AdrSrc),     32'd0);
        check("rst.ALUSrcA",    32'(bus.o_ALUSrcA),    32'd0);
        check("rst.ALUSrcB",    32'(bus.o_ALUSrcB),    32'd2);
        check("rst.ALUOp",      32'(bus.o_ALUOp),      32'd0);
        check("rst.ResultSrc",  32'(bus.o_ResultSrc),  32'd2);
        check("rst.memTimeout", 32'(bus.o_memTimeout), 32'(exp_to));
        exp_to = 1'b0;
        stall_run = 0;
    endtask

    task automatic run_trace(input int cut);
        for (int i = 0; i < cut; i++) run_cycle(trace[i]);
    endtask

    function automatic bit [6:0] pick_opcode();
        bit [6:0] o;
        case ($urandom_range(0, 6))
            0: o = LOAD;
            1: o = STORE;
            2: o = RTYPE;
            3: o = ITYPE;
            4: o = BRANCH;
            5: o = JAL;
            default: begin
                o = 7'($urandom);
                while (o == LOAD || o == STORE || o == RTYPE || o == ITYPE ||
                       o == BRANCH || o == JAL) o = 7'($urandom);
            end
        endcase
        return o;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int fst, mst, cut;
        rst = 1'b1;
        bus.i_opcode = '0; bus.i_funct3 = '0; bus.i_zero = 1'b0; bus.i_memReady = 1'b0;
        run_reset_cycle();
        run_reset_cycle();

        // Directed: R-type, lw with 3 read stalls, branches, unsupported opcode.
        build_instr(RTYPE, 3'b000, 0, 0, -1); run_trace(trace.size());
        build_instr(LOAD, 3'b010, 0, 3, -1);
        check("lw.cycles", 32'(trace.size()), 32'd8);
        run_trace(trace.size());
        build_instr(BRANCH, 3'b000, 0, 0, 1); run_trace(trace.size());
        build_instr(BRANCH, 3'b000, 0, 0, 0); run_trace(trace.size());
        build_instr(BRANCH, 3'b001, 0, 0, 0); run_trace(trace.size());
        build_instr(7'b0110111, 3'b000, 0, 0, -1); run_trace(trace.size());

        // Directed: fetch stalls past the limit, then flag persists.
        build_instr(ITYPE, 3'b000, 6, 0, -1); run_trace(trace.size());
        build_instr(STORE, 3'b010, 0, 5, -1);
        run_trace(5);
        check("timeout.sticky", 32'(bus.o_memTimeout), 32'd1);
        // Reset during the store stall: aborts it and clears the flag.
        run_reset_cycle();
        build_instr(JAL, 3'b000, 0, 0, -1); run_trace(trace.size());

        // Random instruction stream with stalls and occasional resets.
        for (int n = 0; n < 300; n++) begin
            fst = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 1);
            mst = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2);
            build_instr(pick_opcode(), 3'($urandom), fst, mst, -1);
            if ($urandom_range(0, 11) == 0) begin
                cut = $urandom_range(0, trace.size() - 1);
                run_trace(cut);
                run_reset_cycle();
            end else begin
                run_trace(trace.size());
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
